if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end for the pipelined CPU; replaces the single-register IF stage.
//  Issues in-order requests to instruction memory over valid/ready and buffers returned words in a DEPTH-entry queue.
//  Presents {inst, pc, pc+4} to ID over valid/ready; on redirect (branch/jump/jr/IRQ) it flushes and drops stale responses.
// PARAMETERS
//  XLEN      32            address/instruction width
//  DEPTH     4             queue entries and max in-flight requests; power of 2, >=2
//  RESET_PC  32'h0000_0000 fetch address after reset
//  PC_STEP   4             byte increment per fetch
// PORTS
//  clk             in   1                 single clock, all logic on posedge
//  reset           in   1                 asynchronous, active-low (0 = in reset)
//  redirect_valid  in   1                 flush and restart fetch at redirect_pc
//  redirect_pc     in   XLEN              new fetch address
//  imem_req_valid  out  1                 request valid
//  imem_req_ready  in   1                 memory accepts request
//  imem_req_addr   out  XLEN              request address (= fetch_pc)
//  imem_rsp_valid  in   1                 response valid, in request order, latency >=1
//  imem_rsp_data   in   XLEN              instruction word
//  id_valid        out  1                 entry available to ID
//  id_ready        in   1                 ID accepts; 0 = ID stall
//  id_inst         out  XLEN              instruction at queue head
//  id_pc           out  XLEN              its address
//  id_pc_4         out  XLEN              id_pc + PC_STEP, same bit-(XLEN-1) rule as fetch_pc
//  occupancy       out  $clog2(DEPTH)+1   valid queue entries
// BEHAVIOUR
//  Reset (reset==0, async): fetch_pc=RESET_PC; queue, in-flight and discard counts=0; state=RUN;
//   imem_req_valid=0, id_valid=0, occupancy=0; id_* outputs 0.
//  imem_req_valid = reset & ~redirect_valid & (occupancy + inflight < DEPTH). Accept when valid&ready:
//   fetch_pc pushed to in-flight address queue, inflight+1, fetch_pc += PC_STEP.
//  fetch_pc increment: bit XLEN-1 (supervisor flag) preserved; low XLEN-1 bits wrap modulo 2^(XLEN-1).
//  imem_rsp_valid with discard==0: pop in-flight address, push {addr,data}; id_valid next cycle (latency 1).
//   Credit check guarantees no overflow; rsp_valid with inflight==0 is a protocol error (assertion; ignored).
//  ID handshake id_valid&id_ready pops head; empty -> id_valid=0. Queue full (DEPTH) -> no new requests.
//  FSM RUN/DRAIN: redirect_valid -> fetch_pc<=redirect_pc, queue cleared, in-flight addr queue cleared,
//   discard<=inflight after this cycle's rsp; state=DRAIN if discard>0 else RUN.
//   DRAIN: each rsp discarded, discard-1; discard reaches 0 -> RUN. New requests allowed in DRAIN
//   (in-order: they return after the discarded ones); inflight counts both.
//  Simultaneous: redirect+rsp same cycle -> rsp discarded, discard=inflight-1. redirect+ID handshake -> head
//   consumed, then flush. redirect during DRAIN -> discard reloaded with current inflight. Redirect wins over
//   fill. Same-cycle push+pop on full or empty queue both legal; occupancy unchanged.
//  Reset asserted mid-transaction: all state cleared; responses to pre-reset requests must not arrive after
//   release (system requirement on imem).
// CONFIGURATION
//  IFQ_BYPASS_EN defined: rsp with queue empty, discard==0, id_ready=1 -> forwarded combinationally to id_*
//   same cycle, id_valid=1, not enqueued (0-cycle latency). Undefined: always enqueued, latency 1, no
//   comb path rsp->id_*.
// STRUCTURE
//  cpu_pkg: XLEN, PC_STEP, RESET_PC defaults; ifq_state_t {RUN, DRAIN}; supervisor-bit index constant.
//  Sub-module sync_fifo_p (WIDTH, DEPTH; push/pop/flush, count, async active-low reset), instanced twice:
//   in-flight address queue (XLEN) and instruction queue (2*XLEN).
// TESTING
//  Reset, ready=1, rsp latency 1, id_ready=1 -> addrs 0,4,8,..., id_pc follows, id_pc_4=id_pc+4.
//  id_ready=0, DEPTH=4 -> 4 requests then imem_req_valid=0, occupancy=4; id_ready=1 -> resumes, no loss.
//  3 in flight, redirect to 0x100 -> next 3 rsp dropped, first id_pc=0x100, state back to RUN.
//  redirect same cycle as rsp, inflight=2 -> discard=1, only 1 further rsp dropped.
//  fetch_pc=0xFFFF_FFFC -> next 0x8000_0000; fetch_pc=0x7FFF_FFFC -> next 0x0000_0000.
//  IFQ_BYPASS_EN, empty queue, rsp 0x2408_0001 -> id_inst valid same cycle; undefined -> next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch-queue types
// Purpose: default widths and reset vector for the fetch front end,
//          the prefetch-queue state type and the supervisor-bit index.
// Ports:   none (package).
package cpu_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam int          PC_STEP_DEF  = 4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   // Top address bit carries the supervisor flag and never changes on increment.
   localparam int          SUP_BIT_DEF  = XLEN_DEF - 1;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } ifq_state_t;

endpackage

// File: rtl/sync_fifo_p.sv
// rtl/sync_fifo_p.sv - synchronous FIFO with flush and occupancy count
// Purpose: DEPTH-entry first-in first-out store (DEPTH a power of 2).
// Ports:
//   clk       in   clock, posedge
//   rst_n     in   asynchronous active-low reset
//   push      in   write push_data (ignored when full unless popping too)
//   push_data in   WIDTH
//   pop       in   drop the head entry (ignored when empty)
//   flush     in   empty the FIFO; takes priority over push/pop
//   pop_data  out  WIDTH head entry (stale when count==0)
//   count     out  $clog2(DEPTH)+1 valid entries
module sync_fifo_p #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int             AW      = $clog2(DEPTH);
   localparam int             CW      = AW + 1;
   localparam logic [CW-1:0]  DEPTH_W = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      // A full FIFO can still take a write when the head leaves in the same cycle.
      do_push  = push && ((count_q != DEPTH_W) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - instruction prefetch queue feeding the ID stage
// Purpose: issues in-order fetch requests, buffers returned words, hands
//          {inst, pc, pc+step} to ID, and flushes / drops stale responses
//          on redirect. Optional macro IFQ_BYPASS_EN forwards a response
//          straight to ID in the same cycle when the queue is empty.
// Ports:
//   clk, reset                       clock; asynchronous active-low reset
//   redirect_valid, redirect_pc      flush and restart fetch
//   imem_req_valid/ready/addr        request channel to instruction memory
//   imem_rsp_valid/data              in-order responses, latency >= 1
//   id_valid/ready, id_inst/pc/pc_4  decode-side handshake and payload
//   occupancy                        valid queue entries
module if_prefetch_queue
   import cpu_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter int              PC_STEP  = PC_STEP_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    redirect_valid,
   input  logic [XLEN-1:0]         redirect_pc,
   output logic                    imem_req_valid,
   input  logic                    imem_req_ready,
   output logic [XLEN-1:0]         imem_req_addr,
   input  logic                    imem_rsp_valid,
   input  logic [XLEN-1:0]         imem_rsp_data,
   output logic                    id_valid,
   input  logic                    id_ready,
   output logic [XLEN-1:0]         id_inst,
   output logic [XLEN-1:0]         id_pc,
   output logic [XLEN-1:0]         id_pc_4,
   output logic [$clog2(DEPTH):0]  occupancy
);

   localparam int               CW      = $clog2(DEPTH) + 1;
   localparam int               SUP_BIT = XLEN - 1;
   localparam logic [CW:0]      DEPTH_W = (CW + 1)'(DEPTH);
   localparam logic [XLEN-2:0]  STEP_W  = (XLEN - 1)'(PC_STEP);

   // Supervisor bit rides along unchanged; the low bits wrap on their own.
   function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
      logic [XLEN-2:0] low;
      low = pc[SUP_BIT-1:0] + STEP_W;
      return {pc[SUP_BIT], low};
   endfunction

   ifq_state_t        state_q, state_d;
   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]     discard_q, discard_d;

   logic [CW-1:0]     addr_count, inst_count;
   logic [XLEN-1:0]   addr_head;
   logic [2*XLEN-1:0] inst_head;
   logic [CW:0]       inflight;
   logic [CW-1:0]     reload;
   logic              req_fire, rsp_live, bypass, inst_push, inst_pop;
   logic [XLEN-1:0]   head_pc;

   // Outstanding requests are the ones still tracked by address plus the
   // stale ones we have promised to throw away.
   assign inflight       = {1'b0, addr_count} + {1'b0, discard_q};
   assign imem_req_valid = reset && !redirect_valid
                           && (({1'b0, occupancy} + inflight) < DEPTH_W);
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_live       = imem_rsp_valid && !redirect_valid
                           && (discard_q == '0) && (addr_count != '0);

`ifdef IFQ_BYPASS_EN
   assign bypass = rsp_live && (inst_count == '0) && id_ready;
`else
   assign bypass = 1'b0;
`endif

   assign inst_push = rsp_live && !bypass;
   assign inst_pop  = id_ready && (inst_count != '0);
   assign occupancy = inst_count;

   sync_fifo_p #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_q (
      .clk       (clk),
      .rst_n     (reset),
      .push      (req_fire),
      .push_data (fetch_pc_q),
      .pop       (rsp_live),
      .flush     (redirect_valid),
      .pop_data  (addr_head),
      .count     (addr_count)
   );

   sync_fifo_p #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_inst_q (
      .clk       (clk),
      .rst_n     (reset),
      .push      (inst_push),
      .push_data ({addr_head, imem_rsp_data}),
      .pop       (inst_pop),
      .flush     (redirect_valid),
      .pop_data  (inst_head),
      .count     (inst_count)
   );

   always_comb begin
      id_valid = (inst_count != '0) || bypass;
      id_inst  = '0;
      head_pc  = '0;
      if (inst_count != '0) begin
         id_inst = inst_head[XLEN-1:0];
         head_pc = inst_head[2*XLEN-1:XLEN];
      end else if (bypass) begin
         id_inst = imem_rsp_data;
         head_pc = addr_head;
      end
      id_pc   = head_pc;
      id_pc_4 = id_valid ? pc_inc(head_pc) : '0;
   end

   always_comb begin
      // A response arriving in the redirect cycle is already accounted for.
      reload = inflight[CW-1:0]
               - {{(CW - 1){1'b0}}, (imem_rsp_valid && (inflight != '0))};
      discard_d  = discard_q;
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) begin
         discard_d  = reload;
         fetch_pc_d = redirect_pc;
      end else begin
         if (imem_rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
         end
         if (req_fire) begin
            fetch_pc_d = pc_inc(fetch_pc_q);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (discard_d != '0) state_d = DRAIN;
         DRAIN:   if (discard_d == '0) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         discard_q  <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         discard_q  <= discard_d;
      end
   end

   a_rsp_has_credit: assert property (@(posedge clk) disable iff (!reset)
      imem_rsp_valid |-> (inflight != '0));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - self-checking bench for if_prefetch_queue
module tb_if_prefetch_queue;

   localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_pc_4;
   logic [2:0]  occupancy;

   if_prefetch_queue #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_inst        (id_inst),
      .id_pc          (id_pc),
      .id_pc_4        (id_pc_4),
      .occupancy      (occupancy)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
   typedef struct { logic [31:0] rpc; logic [31:0] a0; logic [31:0] a1; logic [31:0] a2; } vec_t;

   pend_t       pend[$];
   ent_t        mq[$];
   logic [31:0] acc_addrs[$];
   logic [31:0] exp_fetch, next_id_pc, last_pop_pc, last_pop_inst;
   int          cyc, last_due, n_pops;
   int          n_checks, n_err;
   bit          drv_redirect, drv_req_ready, drv_id_ready, drv_rsp_en;
   logic [31:0] drv_redirect_pc;
   int          drv_lat;
   bit          s_rsp, s_idv;

   function automatic logic [31:0] inc(input logic [31:0] a);
      return {a[31], a[30:0] + 31'd4};
   endfunction

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h0000_0200) return 32'h2408_0001;
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // One clock: drive, check outputs against the model mid-cycle, advance the model.
   task automatic step();
      bit          rsp_v, stale, byp, exp_idv, exp_rv, fire, hs;
      logic [31:0] epc, einst;
      pend_t       p;
      redirect_valid = drv_redirect;
      redirect_pc    = drv_redirect_pc;
      imem_req_ready = drv_req_ready;
      id_ready       = drv_id_ready;
      rsp_v          = (pend.size() > 0) && (pend[0].due <= cyc) && drv_rsp_en;
      imem_rsp_valid = rsp_v;
      imem_rsp_data  = rsp_v ? memf(pend[0].addr) : 32'h0;
      stale          = rsp_v && (pend[0].stale || drv_redirect);
      #4;
      byp     = BYP && rsp_v && !stale && (mq.size() == 0) && drv_id_ready;
      exp_idv = (mq.size() > 0) || byp;
      epc = 32'h0; einst = 32'h0;
      if (mq.size() > 0) begin
         epc = mq[0].pc; einst = mq[0].inst;
      end else if (byp) begin
         epc = pend[0].addr; einst = memf(pend[0].addr);
      end
      exp_rv = !drv_redirect && ((mq.size() + pend.size()) < DEPTH);
      chk("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", imem_req_addr, exp_fetch);
      chk("id_valid", id_valid, exp_idv);
      chk("id_inst", id_inst, einst);
      chk("id_pc", id_pc, epc);
      chk("id_pc_4", id_pc_4, exp_idv ? inc(epc) : 32'h0);
      chk("occupancy", occupancy, mq.size());
      s_rsp = rsp_v;
      s_idv = id_valid;
      fire  = exp_rv && drv_req_ready;
      hs    = exp_idv && drv_id_ready;
      if (hs) begin
         chk("id_stream", id_pc, next_id_pc);
         next_id_pc    = inc(epc);
         last_pop_pc   = epc;
         last_pop_inst = einst;
         n_pops++;
         if (mq.size() > 0) void'(mq.pop_front());
      end
      if (rsp_v) begin
         p = pend.pop_front();
         if (!stale && !byp) mq.push_back('{pc: p.addr, inst: memf(p.addr)});
      end
      if (drv_redirect) begin
         mq.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
         next_id_pc = drv_redirect_pc;
         exp_fetch  = drv_redirect_pc;
      end
      if (fire) begin
         p.addr  = exp_fetch;
         p.due   = (cyc + drv_lat > last_due) ? cyc + drv_lat : last_due;
         p.stale = 1'b0;
         last_due = p.due;
         pend.push_back(p);
         acc_addrs.push_back(exp_fetch);
         exp_fetch = inc(exp_fetch);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      int n = 0;
      drv_req_ready = 1'b0; drv_id_ready = 1'b1; drv_rsp_en = 1'b1; drv_redirect = 1'b0;
      while (((pend.size() > 0) || (mq.size() > 0)) && (n < 200)) begin
         step();
         n++;
      end
      chk("drain_done", n < 200, 1);
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      drv_redirect = 1'b1; drv_redirect_pc = pc;
      step();
      drv_redirect = 1'b0;
   endtask

   task automatic run_until_accepted(input int k);
      int n = 0;
      while ((acc_addrs.size() < k) && (n < 50)) begin
         step();
         n++;
      end
      chk("accept_timeout", n < 50, 1);
   endtask

   vec_t vecs[4];

   initial begin
      int n, p0;
      n_checks = 0; n_err = 0; cyc = 0; last_due = 0; n_pops = 0;
      exp_fetch = 32'h0; next_id_pc = 32'h0;
      drv_redirect = 0; drv_redirect_pc = 0; drv_req_ready = 0; drv_id_ready = 0;
      drv_rsp_en = 1; drv_lat = 1;
      redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0; imem_rsp_valid = 0;
      imem_rsp_data = 0; id_ready = 0;

      vecs[0] = '{rpc: 32'h0000_0100, a0: 32'h0000_0100, a1: 32'h0000_0104, a2: 32'h0000_0108};
      vecs[1] = '{rpc: 32'hFFFF_FFF8, a0: 32'hFFFF_FFF8, a1: 32'hFFFF_FFFC, a2: 32'h8000_0000};
      vecs[2] = '{rpc: 32'h7FFF_FFF8, a0: 32'h7FFF_FFF8, a1: 32'h7FFF_FFFC, a2: 32'h0000_0000};
      vecs[3] = '{rpc: 32'h8000_1000, a0: 32'h8000_1000, a1: 32'h8000_1004, a2: 32'h8000_1008};

      // Reset values
      reset = 1'b0;
      id_ready = 1'b1; imem_req_ready = 1'b1;
      repeat (3) @(posedge clk);
      #4;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_id_valid", id_valid, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_id_inst", id_inst, 0);
      chk("rst_id_pc", id_pc, 0);
      chk("rst_id_pc_4", id_pc_4, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Streaming from reset: addresses 0,4,8
      drv_req_ready = 1; drv_id_ready = 1; drv_lat = 1;
      run_until_accepted(3);
      chk("reset_addr0", acc_addrs[0], 32'h0);
      chk("reset_addr1", acc_addrs[1], 32'h4);
      chk("reset_addr2", acc_addrs[2], 32'h8);
      repeat (6) step();

      // Redirect target and pc wrap table
      for (int v = 0; v < 4; v++) begin
         drain();
         do_redirect(vecs[v].rpc);
         acc_addrs.delete();
         drv_req_ready = 1; drv_id_ready = 1; drv_lat = 1;
         run_until_accepted(3);
         chk("vec_a0", acc_addrs[0], vecs[v].a0);
         chk("vec_a1", acc_addrs[1], vecs[v].a1);
         chk("vec_a2", acc_addrs[2], vecs[v].a2);
         repeat (4) step();
      end

      // ID stall fills the queue and stops requests, then drains without loss
      drain();
      acc_addrs.delete();
      drv_req_ready = 1; drv_id_ready = 0; drv_lat = 1;
      repeat (12) step();
      chk("stall_occupancy", occupancy, DEPTH);
      chk("stall_req_valid", imem_req_valid, 0);
      chk("stall_accepted", acc_addrs.size(), DEPTH);
      p0 = n_pops;
      drv_req_ready = 0; drv_id_ready = 1;
      repeat (8) step();
      chk("stall_popped", n_pops - p0, DEPTH);

      // Three in flight, redirect: all three dropped
      drain();
      drv_lat = 10; drv_req_ready = 1; drv_id_ready = 1;
      repeat (3) step();
      drv_req_ready = 0;
      do_redirect(32'h0000_0100);
      chk("drain3_state", dut.state_q, cpu_pkg::DRAIN);
      chk("drain3_discard", dut.discard_q, 3);
      drv_req_ready = 1; drv_lat = 1;
      p0 = n_pops; n = 0;
      while ((n_pops == p0) && (n < 60)) begin step(); n++; end
      chk("drain3_first_pc", last_pop_pc, 32'h0000_0100);
      chk("drain3_run", dut.state_q, cpu_pkg::RUN);

      // Redirect in the same cycle as a response with two in flight
      drain();
      drv_lat = 3; drv_req_ready = 1; drv_id_ready = 1;
      repeat (2) step();
      drv_req_ready = 0; n = 0;
      while (!((pend.size() > 0) && (pend[0].due <= cyc)) && (n < 20)) begin step(); n++; end
      do_redirect(32'h0000_0400);
      chk("same_cyc_discard", dut.discard_q, 1);
      chk("same_cyc_state", dut.state_q, cpu_pkg::DRAIN);
      n = 0;
      while ((pend.size() > 0) && (n < 20)) begin step(); n++; end
      chk("same_cyc_run", dut.state_q, cpu_pkg::RUN);
      drv_req_ready = 1; drv_lat = 1; p0 = n_pops; n = 0;
      while ((n_pops == p0) && (n < 30)) begin step(); n++; end
      chk("same_cyc_first_pc", last_pop_pc, 32'h0000_0400);

      // Response latency to ID with an empty queue
      drain();
      do_redirect(32'h0000_0200);
      drv_lat = 1; drv_req_ready = 1; drv_id_ready = 1;
      step();
      drv_req_ready = 0;
      step();
      chk("byp_rsp_seen", s_rsp, 1);
      chk("byp_same_cycle", s_idv, BYP);
      step();
      chk("byp_next_cycle", s_idv, !BYP);
      chk("byp_inst", last_pop_inst, 32'h2408_0001);

      // Randomised traffic against the model
      for (int i = 0; i < 2500; i++) begin
         drv_req_ready = ($urandom % 4) != 0;
         drv_id_ready  = ($urandom % 3) != 0;
         drv_rsp_en    = ($urandom % 4) != 0;
         drv_lat       = 1 + ($urandom % 4);
         drv_redirect  = ($urandom % 16) == 0;
         case ($urandom % 4)
            0:       drv_redirect_pc = 32'h7FFF_FFF0;
            1:       drv_redirect_pc = 32'hFFFF_FFF4;
            default: drv_redirect_pc = $urandom & 32'hFFFF_FFFC;
         endcase
         step();
      end
      drv_redirect = 0;
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
